// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one sequential 8x8 multiplier among NREQ clients.
// Grants one request at a time, sequences start/busy with timeouts, returns the product.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | arbitrate among req_valid_i, latch operands of the winner
// S_ISSUE     | one-cycle mult_start_o pulse
// S_WAIT_BUSY | wait for mult_busy_i to rise (bounded by BUSY_WAIT)
// S_RUN       | wait for mult_busy_i to fall (bounded by RUN_MAX)
// S_RESP      | present response to the granted client until it accepts
module mult_arbiter #(
  parameter int NREQ      = 4,
  parameter int BUSY_WAIT = 4,
  parameter int RUN_MAX   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_a_i,
  input  logic [8*NREQ-1:0] req_b_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [NREQ-1:0]   resp_valid_o,
  input  logic [NREQ-1:0]   resp_ready_i,
  output logic [15:0]       resp_y_o,
  output logic              resp_err_o,
  output logic              mult_start_o,
  output logic [7:0]        mult_a_o,
  output logic [7:0]        mult_b_o,
  input  logic              mult_busy_i,
  input  logic [15:0]       mult_y_i
);

  localparam int IW   = $clog2(NREQ);
  localparam int TMAX = (BUSY_WAIT > RUN_MAX) ? BUSY_WAIT : RUN_MAX;
  localparam int CW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_RUN,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] gsel_q, gsel_d;
  logic [7:0]    a_q, a_d;
  logic [7:0]    b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   y_q, y_d;
  logic          err_q, err_d;

  logic          gnt_found;
  logic [IW-1:0] gnt_idx;
  logic [7:0]    a_sel, b_sel;

  // Search upward from rr_q+1 with wrap, so the last winner has lowest priority.
  always_comb begin
    int cand;
    cand      = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!gnt_found && req_valid_i[IW'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        a_sel = req_a_i[i*8 +: 8];
        b_sel = req_b_i[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= IW'(NREQ - 1);
      gsel_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gsel_q  <= gsel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gsel_d  = gsel_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          a_d     = a_sel;
          b_d     = b_sel;
          gsel_d  = gnt_idx;
          rr_d    = gnt_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (mult_busy_i) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(BUSY_WAIT)) begin
            y_d     = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RUN: begin
        if (!mult_busy_i) begin
          y_d     = mult_y_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(RUN_MAX)) begin
            y_d     = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (resp_ready_i[gsel_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = '0;
    resp_valid_o = '0;
    if (state_q == S_IDLE && gnt_found && !rst) req_ready_o[gnt_idx] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      resp_valid_o[i] = (state_q == S_RESP) && (gsel_q == IW'(i));
    end
    mult_start_o = (state_q == S_ISSUE);
    mult_a_o     = a_q;
    mult_b_o     = b_q;
    resp_y_o     = y_q;
    resp_err_o   = err_q;
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural multiplier whose busy
// behaviour can be normal, never-rising or stuck-high.
module tb_mult_arbiter;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [8*NREQ-1:0] req_a, req_b;
  logic [15:0]       resp_y, mult_y;
  logic              resp_err, mult_start, mult_busy;
  logic [7:0]        mult_a, mult_b;

  int tot  = 0;
  int pass = 0;
  int mode = 0;   // 0 normal, 1 busy never rises, 2 busy stuck high
  int bcnt = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.NREQ(NREQ), .BUSY_WAIT(4), .RUN_MAX(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b), .req_ready_o(req_ready),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_y_o(resp_y), .resp_err_o(resp_err),
    .mult_start_o(mult_start), .mult_a_o(mult_a), .mult_b_o(mult_b),
    .mult_busy_i(mult_busy), .mult_y_i(mult_y)
  );

  // Multiplier model: busy high for 8 cycles after start, product valid on fall.
  always @(posedge clk) begin
    if (rst) begin
      mult_busy <= 1'b0;
      mult_y    <= '0;
      bcnt      <= 0;
    end else if (mult_start && mode != 1) begin
      mult_busy <= 1'b1;
      bcnt      <= 8;
    end else if (mult_busy && mode == 0) begin
      if (bcnt == 1) begin
        mult_busy <= 1'b0;
        mult_y    <= {8'h00, mult_a} * {8'h00, mult_b};
      end
      bcnt <= bcnt - 1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    while (req_ready == '0 && cyc < 60) begin
      step();
      cyc++;
    end
    if (req_ready == '0) cyc = -1;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (resp_valid == '0 && cyc < 60) begin
      step();
      cyc++;
    end
    if (resp_valid == '0) cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0; mode = 0;
    step(); step();
    tot++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got %b exp 0000", req_ready); else pass++;
    tot++; if (resp_valid !== 4'b0000) $display("FAIL reset_resp_valid got %b exp 0000", resp_valid); else pass++;
    tot++; if (resp_y !== 16'h0 || resp_err !== 1'b0) $display("FAIL reset_resp got y=%h err=%b exp 0/0", resp_y, resp_err); else pass++;
    tot++; if (mult_start !== 1'b0 || mult_a !== 8'h0 || mult_b !== 8'h0)
      $display("FAIL reset_mult got start=%b a=%h b=%h exp 0", mult_start, mult_a, mult_b); else pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int cyc;
    set_op(2, 8'h0F, 8'h03);
    req_valid = 4'b0100;
    #1;
    tot++; if (req_ready !== 4'b0100) $display("FAIL single_ready got %b exp 0100", req_ready); else pass++;
    step();
    req_valid = '0;
    tot++; if (mult_start !== 1'b1 || mult_a !== 8'h0F || mult_b !== 8'h03)
      $display("FAIL single_issue got start=%b a=%h b=%h exp 1/0f/03", mult_start, mult_a, mult_b); else pass++;
    step();
    tot++; if (mult_start !== 1'b0) $display("FAIL single_start_len got %b exp 0", mult_start); else pass++;
    wait_resp(cyc);
    tot++; if (cyc < 0) $display("FAIL single_resp_timeout got none exp resp"); else pass++;
    tot++; if (resp_valid !== 4'b0100 || resp_y !== 16'h002D || resp_err !== 1'b0)
      $display("FAIL single_resp got v=%b y=%h e=%b exp 0100/002d/0", resp_valid, resp_y, resp_err); else pass++;
    resp_ready = 4'b0100;
    step();
    tot++; if (resp_valid !== 4'b0000) $display("FAIL single_resp_clear got %b exp 0000", resp_valid); else pass++;
    resp_ready = '0;
  endtask

  task automatic test_all_four();
    int cyc;
    logic [3:0]  exp_g [5];
    logic [15:0] exp_y [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_y = '{16'h0006, 16'h001E, 16'h0038, 16'h0100, 16'h0006};
    rst = 1'b1; step(); rst = 1'b0;
    set_op(0, 8'd2, 8'd3); set_op(1, 8'd5, 8'd6); set_op(2, 8'd7, 8'd8); set_op(3, 8'h10, 8'h10);
    resp_ready = 4'b1111;
    req_valid  = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      wait_grant(cyc);
      tot++; if (req_ready !== exp_g[n]) $display("FAIL rr_grant%0d got %b exp %b", n, req_ready, exp_g[n]); else pass++;
      step();
      if (n == 4) req_valid = '0;
      wait_resp(cyc);
      tot++; if (resp_valid !== exp_g[n] || resp_y !== exp_y[n] || resp_err !== 1'b0)
        $display("FAIL rr_resp%0d got v=%b y=%h e=%b exp %b/%h/0", n, resp_valid, resp_y, resp_err, exp_g[n], exp_y[n]); else pass++;
    end
    step();
  endtask

  task automatic test_back_to_back();
    int cyc;
    resp_ready = '0;
    set_op(1, 8'd9, 8'd9); set_op(3, 8'd4, 8'h0C);
    req_valid = 4'b0010;
    #1;
    wait_grant(cyc);
    tot++; if (req_ready !== 4'b0010) $display("FAIL bp_grant got %b exp 0010", req_ready); else pass++;
    step();
    req_valid = 4'b1000;
    wait_resp(cyc);
    for (int n = 0; n < 10; n++) begin
      tot++; if (resp_valid !== 4'b0010 || resp_y !== 16'h0051 || mult_start !== 1'b0 || req_ready !== 4'b0000)
        $display("FAIL bp_hold%0d got v=%b y=%h st=%b rr=%b exp 0010/0051/0/0000", n, resp_valid, resp_y, mult_start, req_ready);
      else pass++;
      step();
    end
    resp_ready = 4'b1000;
    step();
    tot++; if (resp_valid !== 4'b0010) $display("FAIL bp_other_ready got %b exp 0010", resp_valid); else pass++;
    resp_ready = 4'b0010;
    step();
    tot++; if (resp_valid !== 4'b0000 || req_ready !== 4'b1000)
      $display("FAIL bp_release got v=%b rr=%b exp 0000/1000", resp_valid, req_ready); else pass++;
    resp_ready = 4'b1111;
    step();
    req_valid = '0;
    wait_resp(cyc);
    tot++; if (resp_valid !== 4'b1000 || resp_y !== 16'h0030)
      $display("FAIL bp_next got v=%b y=%h exp 1000/0030", resp_valid, resp_y); else pass++;
    step();
  endtask

  task automatic test_busy_timeout();
    int cyc;
    mode = 1; resp_ready = '0;
    set_op(2, 8'h11, 8'h22);
    req_valid = 4'b0100;
    #1;
    wait_grant(cyc);
    step();
    req_valid = '0;
    wait_resp(cyc);
    tot++; if (cyc !== 5) $display("FAIL bw_latency got %0d exp 5", cyc); else pass++;
    tot++; if (resp_valid !== 4'b0100 || resp_err !== 1'b1 || resp_y !== 16'h0)
      $display("FAIL bw_resp got v=%b e=%b y=%h exp 0100/1/0000", resp_valid, resp_err, resp_y); else pass++;
    mode = 0; resp_ready = 4'b1111;
    step();
    set_op(0, 8'd3, 8'd3);
    req_valid = 4'b0001;
    #1;
    wait_grant(cyc);
    tot++; if (req_ready !== 4'b0001) $display("FAIL bw_next_grant got %b exp 0001", req_ready); else pass++;
    step();
    req_valid = '0;
    wait_resp(cyc);
    tot++; if (resp_valid !== 4'b0001 || resp_err !== 1'b0 || resp_y !== 16'h0009)
      $display("FAIL bw_next_resp got v=%b e=%b y=%h exp 0001/0/0009", resp_valid, resp_err, resp_y); else pass++;
    step();
  endtask

  task automatic test_run_timeout();
    int cyc;
    mode = 2; resp_ready = '0;
    set_op(3, 8'hAB, 8'hCD);
    req_valid = 4'b1000;
    #1;
    wait_grant(cyc);
    step();
    req_valid = '0;
    cyc = 0;
    while (resp_valid == '0 && cyc < 60) begin
      step();
      cyc++;
      tot++; if (mult_a !== 8'hAB || mult_b !== 8'hCD)
        $display("FAIL run_hold got a=%h b=%h exp ab/cd", mult_a, mult_b); else pass++;
    end
    tot++; if (cyc !== 18) $display("FAIL run_latency got %0d exp 18", cyc); else pass++;
    tot++; if (resp_valid !== 4'b1000 || resp_err !== 1'b1 || resp_y !== 16'h0)
      $display("FAIL run_resp got v=%b e=%b y=%h exp 1000/1/0000", resp_valid, resp_err, resp_y); else pass++;
    resp_ready = 4'b1111;
    step();
  endtask

  task automatic test_reset_mid();
    int cyc;
    rst = 1'b1; step(); rst = 1'b0; mode = 0; resp_ready = 4'b1111;
    set_op(2, 8'd1, 8'd2);
    req_valid = 4'b0100;
    #1;
    wait_grant(cyc);
    step();
    req_valid = '0;
    step(); step(); step();
    rst = 1'b1;
    step();
    tot++; if (req_ready !== 4'b0000 || resp_valid !== 4'b0000 || resp_err !== 1'b0 || resp_y !== 16'h0 ||
               mult_start !== 1'b0 || mult_a !== 8'h0 || mult_b !== 8'h0)
      $display("FAIL mid_reset got rr=%b v=%b e=%b y=%h st=%b a=%h b=%h exp all 0",
               req_ready, resp_valid, resp_err, resp_y, mult_start, mult_a, mult_b); else pass++;
    rst = 1'b0;
    set_op(0, 8'd7, 8'd7); set_op(3, 8'd2, 8'd2);
    req_valid = 4'b1001;
    #1;
    tot++; if (req_ready !== 4'b0001) $display("FAIL mid_first_grant got %b exp 0001", req_ready); else pass++;
    step();
    req_valid = 4'b1000;
    wait_resp(cyc);
    tot++; if (resp_valid !== 4'b0001 || resp_y !== 16'h0031)
      $display("FAIL mid_resp got v=%b y=%h exp 0001/0031", resp_valid, resp_y); else pass++;
    step();
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_all_four();
    test_back_to_back();
    test_busy_timeout();
    test_run_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one sequential 8x8 multiplier among NREQ requesters.
- Grants one request at a time and latches its operands. It drives the multiplier start/operand ports, tracks the busy handshake with timeouts, and returns the 16-bit product to the granted requester over a valid/ready response channel.
- Sits between client blocks and the multiplier instance.

Parameters:
NREQ, 4, number of requesters (2..8)
BUSY_WAIT, 4, max cycles from start to mult_busy rising before timeout
RUN_MAX, 16, max cycles mult_busy may stay high before timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request valid, held until accepted
req_a  in  8*NREQ  operand a, slice i = requester i
req_b  in  8*NREQ  operand b, slice i = requester i
req_ready  out  NREQ  one-hot accept pulse
resp_valid  out  NREQ  one-hot response valid, held until resp_ready
resp_ready  in  NREQ  per-requester response accept
resp_y  out  16  product for the requester flagged by resp_valid
resp_err  out  1  qualifies resp_valid: 1 = timeout, resp_y = 0
mult_start  out  1  start strobe to multiplier
mult_a  out  8  operand a to multiplier, held stable for whole operation
mult_b  out  8  operand b to multiplier, held stable for whole operation
mult_busy  in  1  multiplier busy
mult_y  in  16  multiplier product, valid once mult_busy has fallen

Behaviour:
- Reset state (all outputs 0):
  - state = IDLE; rr pointer = NREQ-1, so requester 0 has highest priority first.
  - req_ready, resp_valid, resp_err, resp_y, mult_start, mult_a, mult_b, timeout counter all 0.
  - Reset mid-operation aborts: no response is delivered. The multiplier shares rst.
- States: IDLE, ISSUE, WAIT_BUSY, RUN, RESP.
- IDLE:
  - If any req_valid, grant g = first valid index searching upward from rr+1, wrapping at NREQ.
  - req_ready[g]=1 combinationally in that cycle only.
  - At the edge: latch req_a[g], req_b[g] into mult_a/mult_b; store g; rr <= g; go ISSUE.
  - No valid: stay in IDLE.
- ISSUE: mult_start=1 for exactly this one cycle; clear counter; go WAIT_BUSY.
- WAIT_BUSY:
  - mult_busy=1: go RUN, clear counter.
  - Otherwise increment counter; counter reaching BUSY_WAIT: timeout.
- RUN:
  - mult_busy=0: capture mult_y into resp_y, resp_err=0, go RESP.
  - Otherwise increment counter; counter reaching RUN_MAX: timeout.
- Timeout: resp_y=0, resp_err=1, go RESP.
- RESP:
  - resp_valid[g]=1 with resp_y/resp_err stable.
  - On resp_ready[g]=1: resp_valid clears next cycle, go IDLE.
  - resp_ready of other requesters is ignored.
- mult_a/mult_b are held from grant until the next grant; they never change during an operation.
- The multiplier's ready output is not used; completion is detected only on mult_busy falling.
- Throughput: at most one grant per operation. Minimum turnaround from grant to next grant is 4 cycles + multiplier run time + response wait.
- Simultaneous requests: exactly one req_ready per accepted op. A requester keeps req_valid high until its req_ready.
- The rr pointer updates only on grant, giving fairness: a continuously requesting client waits at most NREQ-1 operations.
- Requests arriving while not in IDLE wait; no queueing beyond req_valid holding.
- req_valid dropping before accept is legal; the request is withdrawn.

Test Plan:
1. Single request: requester 2 sends a=0x0F, b=0x03 with bench multiplier model (busy 8 cycles) -> req_ready[2] pulse, one mult_start cycle with mult_a=0x0F, mult_b=0x03, resp_valid[2] with resp_y=0x002D, resp_err=0.
2. All four requesters valid after reset, resp_ready tied high -> grant order 0,1,2,3,0; each resp_y matches its own operands, e.g. req1 a=5, b=6 -> 0x001E.
3. Response backpressure: resp_ready[1] held low 10 cycles -> resp_valid[1] and resp_y stable for all 10 cycles, no new mult_start until resp_ready[1]=1, then return to IDLE.
4. Busy-never-rises model -> after BUSY_WAIT cycles in WAIT_BUSY, resp_valid[g]=1, resp_err=1, resp_y=0; next request serviced normally.
5. Busy stuck high -> after RUN_MAX cycles in RUN, resp_err=1; mult_a/mult_b unchanged throughout.
6. rst asserted during RUN -> next cycle all outputs 0, state IDLE, rr=NREQ-1; the aborted requester gets no response, and requester 0 wins the next arbitration.
